// File: rtl/prog_cache.sv
// ---------------------------------------------------------------------------
// prog_cache -- direct-mapped, one-word-per-line read cache in front of a
// slow program ROM.
//
// Each line holds one DATA_W word. The low IDX_W address bits select the
// line, the remaining bits form the tag. A hit returns the stored word one
// cycle after the request; a miss issues a single-word ROM read and returns
// the ROM word when it arrives. A flush walks every line clearing one valid
// bit per cycle; the same walk runs after reset.
//
// Optional feature macro: PROG_CACHE_STATS_EN adds saturating hit/miss
// counters (hit_count, miss_count).
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   flush       in   one-cycle pulse: invalidate all lines
//   cache_req   in   CPU read request, held until cache_valid
//   cache_addr  in   CPU word address (ADDR_W)
//   cache_valid out  read data valid
//   cache_data  out  read data (DATA_W)
//   hit         out  combinational lookup hit
//   busy        out  flush walk in progress
//   rom_req     out  ROM read request
//   rom_addr    out  ROM word address (ADDR_W)
//   rom_data    in   ROM read data (DATA_W)
//   rom_valid   in   one-cycle pulse, rom_data valid
//   hit_count   out  [PROG_CACHE_STATS_EN] hits served from the cache
//   miss_count  out  [PROG_CACHE_STATS_EN] misses sent to the ROM
// ---------------------------------------------------------------------------
module prog_cache #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              cache_req,
    input  logic [ADDR_W-1:0] cache_addr,
    output logic              cache_valid,
    output logic [DATA_W-1:0] cache_data,
    output logic              hit,
    output logic              busy,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_valid
`ifdef PROG_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   flush_idx_reg, flush_idx_next;
    logic               flush_pending_reg, flush_pending_next;
    logic               cache_valid_reg, cache_valid_next;
    logic               rom_req_reg, rom_req_next;
    logic [ADDR_W-1:0]  rom_addr_reg, rom_addr_next;
    logic [DATA_W-1:0]  cache_data_reg, cache_data_next;
    // Selects where cache_data comes from: the RAM read register after a
    // hit, or the captured ROM word after a fill.
    logic               data_sel_reg, data_sel_next;

    logic               fill_we;
    logic               flush_clr;

    // Line storage. Data uses a registered read (block RAM); tags need an
    // asynchronous read because hit is combinational. Valid bits live in
    // flops so the flush walk can clear them one per cycle.
    logic [DATA_W-1:0]  data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid_bits;
    logic [DATA_W-1:0]  ram_q;

    logic [IDX_W-1:0]   lookup_idx;
    logic [TAG_W-1:0]   lookup_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;

    assign lookup_idx = cache_addr[IDX_W-1:0];
    assign lookup_tag = cache_addr[ADDR_W-1:IDX_W];
    assign fill_idx   = rom_addr_reg[IDX_W-1:0];
    assign fill_tag   = rom_addr_reg[ADDR_W-1:IDX_W];

    assign hit = valid_bits[lookup_idx]
              && (tag_mem[lookup_idx] == lookup_tag)
              && (state_reg == IDLE)
              && !flush;

    // A rom_valid coinciding with reset must not write the line.
    assign fill_we   = (state_reg == FILL) && rom_valid && !reset;
    assign flush_clr = (state_reg == FLUSH);

    // ------------------------------------------------------------------
    // Line memories
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[fill_idx] <= rom_data;
        end
        // Only sampled in IDLE so the word stays put while DONE holds it.
        if (state_reg == IDLE) begin
            ram_q <= data_mem[lookup_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

    // Valid bits need no reset: reset always starts a full flush walk.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (fill_we && (fill_idx == IDX_W'(gi))) begin
                valid_bits[gi] <= 1'b1;
            end else if (flush_clr && (flush_idx_reg == IDX_W'(gi))) begin
                valid_bits[gi] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= FLUSH;
            flush_idx_reg     <= '0;
            flush_pending_reg <= 1'b0;
            cache_valid_reg   <= 1'b0;
            rom_req_reg       <= 1'b0;
            rom_addr_reg      <= '0;
            cache_data_reg    <= '0;
            data_sel_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            flush_idx_reg     <= flush_idx_next;
            flush_pending_reg <= flush_pending_next;
            cache_valid_reg   <= cache_valid_next;
            rom_req_reg       <= rom_req_next;
            rom_addr_reg      <= rom_addr_next;
            cache_data_reg    <= cache_data_next;
            data_sel_reg      <= data_sel_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        state_next         = state_reg;
        flush_idx_next     = flush_idx_reg;
        flush_pending_next = flush_pending_reg;
        cache_valid_next   = cache_valid_reg;
        rom_req_next       = rom_req_reg;
        rom_addr_next      = rom_addr_reg;
        cache_data_next    = cache_data_reg;
        data_sel_next      = data_sel_reg;

        case (state_reg)
            IDLE: begin
                // flush wins over a simultaneous request
                if (flush) begin
                    state_next     = FLUSH;
                    flush_idx_next = '0;
                end else if (cache_req) begin
                    if (hit) begin
                        cache_valid_next = 1'b1;
                        data_sel_next    = 1'b1;
                        state_next       = DONE;
                    end else begin
                        rom_req_next  = 1'b1;
                        rom_addr_next = cache_addr;
                        state_next    = FILL;
                    end
                end
            end

            FILL: begin
                // The ROM transaction is always completed; a flush seen
                // here waits until the line has been written.
                if (flush) begin
                    flush_pending_next = 1'b1;
                end
                if (rom_valid) begin
                    rom_req_next = 1'b0;
                    if (flush_pending_reg || flush) begin
                        flush_pending_next = 1'b0;
                        flush_idx_next     = '0;
                        state_next         = FLUSH;
                    end else if (cache_req) begin
                        cache_valid_next = 1'b1;
                        cache_data_next  = rom_data;
                        data_sel_next    = 1'b0;
                        state_next       = DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            DONE: begin
                if (flush) begin
                    cache_valid_next = 1'b0;
                    flush_idx_next   = '0;
                    state_next       = FLUSH;
                end else if (!cache_req) begin
                    cache_valid_next = 1'b0;
                    state_next       = IDLE;
                end
            end

            FLUSH: begin
                // Requests and further flush pulses are ignored until the
                // walk reaches the last line.
                flush_idx_next = flush_idx_reg + 1'b1;
                if (flush_idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cache_valid = cache_valid_reg;
    assign cache_data  = data_sel_reg ? ram_q : cache_data_reg;
    assign rom_req     = rom_req_reg;
    assign rom_addr    = rom_addr_reg;
    // Reset parks the FSM in FLUSH; busy starts once reset is released.
    assign busy        = (state_reg == FLUSH) && !reset;

`ifdef PROG_CACHE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating hit/miss counters; flush leaves them alone.
    // ------------------------------------------------------------------
    logic        hit_evt;
    logic        miss_evt;
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    assign hit_evt  = (state_reg == IDLE) && cache_req && hit;
    assign miss_evt = (state_reg == IDLE) && cache_req && !hit && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_evt && (hit_count_reg != 32'hFFFF_FFFF)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss_evt && (miss_count_reg != 32'hFFFF_FFFF)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule
